sample_interp: RTL

SAMPLE_INTERP -- requirements
Module: sample_interp

---
 rtl/sample_interp.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sample_interp.sv
// rtl/sample_interp.sv - input FIFO feeding a linear / zero-order-hold upsampling interpolator
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   in_data       unsigned input sample (WIDTH)
//   in_valid      in_data is valid
//   in_ready      FIFO can accept a sample
//   x1            interpolated sample stream, one value per clk (WIDTH)
//   underflow     sticky: FIFO was empty when a segment ended
//   underflow_clr clears underflow (a coincident underflow event wins)
//   level         FIFO occupancy ($clog2(FIFO_DEPTH)+1)
//
// Build option: SAMPLE_INTERP_LINEAR_EN selects linear interpolation;
// without it each sample is held for OSR cycles (zero-order hold).

module sample_interp #(
  parameter int WIDTH      = 16,
  parameter int LOG2_OSR   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              x1,
  output logic                          underflow,
  input  logic                          underflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int ACCW = WIDTH + LOG2_OSR;
  localparam logic [AW:0]         DEPTH_L    = (AW+1)'(FIFO_DEPTH);
  localparam logic [LOG2_OSR-1:0] LAST_PHASE = '1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  logic [WIDTH-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;

  state_t                  state;
  logic [ACCW-1:0]         acc;
  logic signed [WIDTH:0]   step;
  logic [LOG2_OSR-1:0]     phase;
  logic [WIDTH-1:0]        cur;

  logic                    push;
  logic                    pop;
  logic                    starve;
  logic                    boundary;
  logic [WIDTH-1:0]        head;
  logic [ACCW-1:0]         cur_scaled;
  logic [ACCW-1:0]         step_ext;

  // A full FIFO refuses a push even if the same edge pops.
  assign in_ready = !rst && (level < DEPTH_L);
  assign push     = in_valid && in_ready;

  // Segment boundary: any edge outside RUN, or the last phase of a segment.
  assign boundary = (state != RUN) || (phase == LAST_PHASE);
  assign pop      = boundary && (level != '0);
  assign starve   = (state == RUN) && (phase == LAST_PHASE) && (level == '0);

  assign head       = mem[rd_ptr];
  assign cur_scaled = {cur, {LOG2_OSR{1'b0}}};
  // Sign extension lets a negative step wrap modulo 2^ACCW, which lands
  // exactly on the lower endpoint after OSR additions.
  assign step_ext   = ACCW'(step);

  assign x1 = acc[LOG2_OSR +: WIDTH];

`ifndef SAMPLE_INTERP_LINEAR_EN
  logic [ACCW-1:0] head_scaled;
  assign head_scaled = {head, {LOG2_OSR{1'b0}}};
`endif

  // Sample storage needs no reset; occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      step      <= '0;
      phase     <= '0;
      cur       <= '0;
      underflow <= 1'b0;
    end else begin
      if (pop) begin
`ifdef SAMPLE_INTERP_LINEAR_EN
        // Start the ramp from the held endpoint toward the new sample.
        acc  <= cur_scaled;
        step <= $signed({1'b0, head}) - $signed({1'b0, cur});
`else
        acc  <= head_scaled;
        step <= '0;
`endif
        cur   <= head;
        phase <= '0;
        state <= RUN;
      end else if (starve) begin
        // Land on the endpoint and freeze there until data arrives.
        acc   <= cur_scaled;
        step  <= '0;
        state <= HOLD;
      end else if (state == RUN) begin
        acc   <= acc + step_ext;
        phase <= phase + 1'b1;
      end

      if (starve) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
